// File: rtl/cache_main_memory.sv
// rtl/cache_main_memory.sv - block-granular main-memory responder with fixed access latency (optional MEM_STATS_EN access counters)
module cache_main_memory #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
    parameter int ADDR_WIDTH      = 30,
    parameter int NUM_MEM_BLOCKS  = 1024,
    parameter int MEM_IDX_WIDTH   = $clog2(NUM_MEM_BLOCKS),
    parameter int LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_mem,
    input  logic                  write_en_mem,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] dirty_block_in,
    output logic [BLOCK_SIZE-1:0] data_out_mem,
    output logic                  ready_mem,
    output logic                  busy_mem
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter is 8 bits wide because LATENCY is limited to 1..255.
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t                   state;
    logic                     op_write;
    logic [MEM_IDX_WIDTH-1:0] idx_q;
    logic [BLOCK_SIZE-1:0]    wdata_q;
    logic [7:0]               counter;
    logic                     commit;

    logic [BLOCK_SIZE-1:0]    storage [NUM_MEM_BLOCKS];

    // Address bits above the storage index are deliberately ignored (aliasing).
    generate
        if (ADDR_WIDTH > MEM_IDX_WIDTH) begin : g_addr_upper
            logic unused_addr_upper;
            assign unused_addr_upper = ^mem_addr[ADDR_WIDTH-1:MEM_IDX_WIDTH];
        end
    endgenerate

    // The latched request takes effect on the last BUSY cycle.
    assign commit = (state == BUSY) && (counter == 8'd0);

    // Storage write port; contents survive reset, and a reset edge blocks the commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_write) begin
            storage[idx_q] <= wdata_q;
        end
    end

    // Request FSM: accept in IDLE (write has priority), count down in BUSY, pulse ready in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ready_mem    <= 1'b0;
            busy_mem     <= 1'b0;
            data_out_mem <= '0;
            counter      <= '0;
            op_write     <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_mem <= 1'b0;
                    if (write_en_mem || read_en_mem) begin
                        op_write <= write_en_mem;
                        idx_q    <= mem_addr[MEM_IDX_WIDTH-1:0];
                        if (write_en_mem) begin
                            wdata_q <= dirty_block_in;
                        end
                        counter  <= LAT_M1;
                        busy_mem <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter == 8'd0) begin
                        if (!op_write) begin
                            data_out_mem <= storage[idx_q];
                        end
                        ready_mem <= 1'b1;
                        state     <= RESP;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                RESP: begin
                    ready_mem <= 1'b0;
                    busy_mem  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    ready_mem <= 1'b0;
                    busy_mem  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    // Saturating completion counters, bumped in the RESP cycle of each finished access.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESP) begin
            if (op_write) begin
                if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
            end else begin
                if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule
